exp6_sequenciador_exibicao: RTL and testbench

//  Playback controller: shows the stored memory sequence (addresses 0..limit) on the LEDs before each player round.

---
 rtl/exp6_sequenciador_exibicao_pkg.sv | 16 +
 rtl/exp6_temporizador.sv | 25 ++
 rtl/exp6_sequenciador_exibicao.sv | 121 ++++++++++++
 tb/tb_exp6_sequenciador_exibicao.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/exp6_sequenciador_exibicao_pkg.sv
// State codes for the playback sequencer.
// Shared with the main control unit.
package exp6_sequenciador_exibicao_pkg;

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    INICIA  = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    PROXIMO = 4'h4,
    FIM     = 4'hA
  } estado_t;

  localparam logic [3:0] E_INVALIDO = 4'hF;

endpackage

// File: rtl/exp6_temporizador.sv
// Interval timer: clear has priority over count.
// Never saturates; the FSM clears it on every phase entry.
module exp6_temporizador #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/exp6_sequenciador_exibicao.sv
// Playback sequencer: lights each stored element for
// T_ACESO cycles, then dark for T_APAGADO cycles.
module exp6_sequenciador_exibicao
  import exp6_sequenciador_exibicao_pkg::*;
#(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250,
  parameter int W_T       = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       cancela,
  input  logic       fimE,
  output logic       zeraE,
  output logic       contaE,
  output logic       acende,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t r_estado;
  estado_t w_prox;

  logic [W_T-1:0] w_t;
  logic           w_zera_t;
  logic           w_conta_t;
  logic           w_fim_aceso;
  logic           w_fim_apaga;

  assign w_fim_aceso = (w_t == W_T'(T_ACESO - 1));
  assign w_fim_apaga = (w_t == W_T'(T_APAGADO - 1));

  exp6_temporizador #(
    .W (W_T)
  ) u_temporizador (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera_t),
    .conta (w_conta_t),
    .q     (w_t)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox    = r_estado;
    w_zera_t  = 1'b0;
    w_conta_t = 1'b0;
    zeraE     = 1'b0;
    contaE    = 1'b0;
    acende    = 1'b0;
    ocupado   = 1'b0;
    pronto    = 1'b0;
    db_estado = r_estado;
    case (r_estado)
      OCIOSO: begin
        w_zera_t = 1'b1;
        if (iniciar) begin
          w_prox = INICIA;
        end
      end
      INICIA: begin
        zeraE    = 1'b1;
        ocupado  = 1'b1;
        w_zera_t = 1'b1;
        w_prox   = ACENDE;
      end
      ACENDE: begin
        acende  = 1'b1;
        ocupado = 1'b1;
        if (w_fim_aceso) begin
          w_zera_t = 1'b1;
          w_prox   = APAGA;
        end else begin
          w_conta_t = 1'b1;
        end
      end
      APAGA: begin
        ocupado = 1'b1;
        if (w_fim_apaga) begin
          w_zera_t = 1'b1;
          w_prox   = fimE ? FIM : PROXIMO;
        end else begin
          w_conta_t = 1'b1;
        end
      end
      PROXIMO: begin
        contaE   = 1'b1;
        ocupado  = 1'b1;
        w_zera_t = 1'b1;
        w_prox   = ACENDE;
      end
      FIM: begin
        pronto   = 1'b1;
        ocupado  = 1'b1;
        w_zera_t = 1'b1;
        w_prox   = OCIOSO;
      end
      default: begin
        db_estado = E_INVALIDO;
        w_zera_t  = 1'b1;
        w_prox    = OCIOSO;
      end
    endcase
    // abort overrides every transition
    if (cancela) begin
      w_zera_t  = 1'b1;
      w_conta_t = 1'b0;
      w_prox    = OCIOSO;
    end
  end

endmodule

// File: tb/tb_exp6_sequenciador_exibicao.sv
// Bench for the playback sequencer: schedule-based
// reference model plus directed literal checks.
module tb_exp6_sequenciador_exibicao;

  localparam int TA = 4;
  localparam int TP = 2;
  localparam int P  = TA + TP + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       cancela = 1'b0;
  logic       fimE;
  logic       zeraE, contaE, acende;
  logic       ocupado, pronto;
  logic [3:0] db_estado;

  int  checks = 0;
  int  failures = 0;
  bit  chk_en = 1'b0;
  bit  tie = 1'b0;
  int  lim = 0;
  int  addr = 0;
  int  db_hist [0:63];

  bit  m_ativo = 1'b0;
  int  m_k = 0;
  int  m_n = 1;

  always #5 clk = ~clk;

  exp6_sequenciador_exibicao #(
    .T_ACESO   (TA),
    .T_APAGADO (TP),
    .W_T       (4)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .iniciar   (iniciar),
    .cancela   (cancela),
    .fimE      (fimE),
    .zeraE     (zeraE),
    .contaE    (contaE),
    .acende    (acende),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .db_estado (db_estado)
  );

  // datapath address counter driven by the DUT
  assign fimE = tie ? 1'b1 : (addr == lim);

  always @(posedge clk) begin
    if (zeraE) addr <= 0;
    else if (contaE) addr <= addr + 1;
  end

  // expected {db, zeraE, contaE, acende, ocupado, pronto}
  function automatic logic [8:0] esperado(
    input bit a, input int k, input int n
  );
    int kfim, r;
    kfim = n * P + 1;
    if (!a) return 9'h0;
    if (k == 1) return {4'h1, 5'b10010};
    if (k == kfim) return {4'hA, 5'b00011};
    r = (k - 2) % P;
    if (r < TA) return {4'h2, 5'b00110};
    if (r < TA + TP) return {4'h3, 5'b00010};
    return {4'h4, 5'b01010};
  endfunction

  always @(posedge clk) begin
    if (reset || cancela) begin
      m_ativo = 1'b0;
    end else if (!m_ativo) begin
      if (iniciar) begin
        m_ativo = 1'b1;
        m_k = 1;
        m_n = tie ? 1 : lim + 1;
      end
    end else if (m_k == m_n * P + 1) begin
      m_ativo = 1'b0;
    end else begin
      m_k = m_k + 1;
    end
  end

  always @(negedge clk) begin
    logic [8:0] got, exp;
    if (chk_en) begin
      got = {db_estado, zeraE, contaE,
             acende, ocupado, pronto};
      exp = esperado(m_ativo, m_k, m_n);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h",
                 $time, got, exp);
      end
    end
  end

  task automatic chk(input string nm,
                     input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // starts at a negedge showing cycle 1
  task automatic observar(input int maxc,
    output int pc, output int na,
    output int nc, output int nz);
    pc = -1; na = 0; nc = 0; nz = 0;
    for (int c = 1; c <= maxc; c++) begin
      if (pronto && pc < 0) pc = c;
      na += int'(acende);
      nc += int'(contaE);
      nz += int'(zeraE);
      if (c < 64) db_hist[c] = int'(db_estado);
      @(negedge clk);
    end
  endtask

  task automatic pulso_iniciar();
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  initial begin
    int pc, na, nc, nz;
    // 1: reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_db", int'(db_estado), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_outs", int'({zeraE, contaE, acende, pronto}), 0);
    reset = 1'b0;
    @(negedge clk);

    // 2: single element, fimE tied high
    tie = 1'b1;
    pulso_iniciar();
    observar(12, pc, na, nc, nz);
    chk("t2_pronto_cycle", pc, 8);
    chk("t2_acende_cycles", na, 4);
    chk("t2_zeraE_cycles", nz, 1);
    chk("t2_contaE_cycles", nc, 0);
    tie = 1'b0;

    // 3: three elements
    lim = 2;
    pulso_iniciar();
    observar(26, pc, na, nc, nz);
    chk("t3_pronto_cycle", pc, 22);
    chk("t3_acende_cycles", na, 12);
    chk("t3_contaE_cycles", nc, 2);
    chk("t3_db_fim", db_hist[22], 10);
    chk("t3_db_after", db_hist[23], 0);
    chk("t3_addr", addr, 2);

    // 4: cancel during second ACENDE (cycles 9..12)
    pulso_iniciar();
    observar(10, pc, na, nc, nz);
    chk("t4_db_acende", int'(db_estado), 2);
    cancela = 1'b1;
    @(negedge clk);
    cancela = 1'b0;
    chk("t4_acende", int'(acende), 0);
    chk("t4_ocupado", int'(ocupado), 0);
    observar(20, pc, na, nc, nz);
    chk("t4_no_pronto", pc, -1);
    chk("t4_no_contaE", nc, 0);
    chk("t4_addr", addr, 1);

    // 5: iniciar held through a whole run
    lim = 0;
    iniciar = 1'b1;
    @(negedge clk);
    observar(10, pc, na, nc, nz);
    chk("t5_pronto_cycle", pc, 8);
    chk("t5_db_idle", db_hist[9], 0);
    chk("t5_db_restart", db_hist[10], 1);
    chk("t5_zeraE", nz, 2);
    iniciar = 1'b0;
    observar(12, pc, na, nc, nz);

    // 6: reset mid-APAGA (cycles 6..7)
    lim = 1;
    pulso_iniciar();
    observar(5, pc, na, nc, nz);
    chk("t6_db_apaga", int'(db_estado), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_rst_ocupado", int'(ocupado), 0);
    chk("t6_rst_db", int'(db_estado), 0);
    observar(15, pc, na, nc, nz);
    chk("t6_rst_no_pronto", pc, -1);
    iniciar = 1'b1;
    cancela = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    cancela = 1'b0;
    chk("t6_both_ocupado", int'(ocupado), 0);
    chk("t6_both_db", int'(db_estado), 0);
    observar(5, pc, na, nc, nz);
    chk("t6_both_zeraE", nz, 0);

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      iniciar = ($urandom_range(0, 7) == 0);
      cancela = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if (!m_ativo && !iniciar)
        lim = $urandom_range(0, 3);
      @(negedge clk);
    end
    iniciar = 1'b0;
    cancela = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
